fifo_unpacker: RTL and testbench
================================

Name: fifo_unpacker

Overview:
- Downstream drain stage for the team's synchronous FIFO.
- Pops one WIDTH-bit word from the FIFO read port and serialises it into RATIO narrower beats on a valid/ready output stream.
- Sustains one beat per cycle across word boundaries with no bubbles while the FIFO is non-empty.
- Sits between the FIFO and any narrow consumer, e.g. a link or bus width adapter.

Parameters:
- WIDTH, 256, FIFO word width in bits. Must equal the FIFO's WIDTH.
- OUT_WIDTH, 32, output beat width in bits. WIDTH must be an integer multiple of OUT_WIDTH, with ratio >= 2.
- CNT_WIDTH, 16, width of the completed-word counter.
- RATIO (localparam), WIDTH/OUT_WIDTH, number of beats per word.
- BLG2 (localparam), $clog2(RATIO), beat index width.

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  reset, asynchronous, active-low (asserted when 0)
- fifo_empty  input  1  FIFO empty flag
- fifo_rd_data  input  WIDTH  FIFO head word; combinational from the FIFO read pointer
- fifo_rd  output  1  pop strobe to the FIFO rd input
- out_valid  output  1  beat valid
- out_ready  input  1  consumer ready
- out_data  output  OUT_WIDTH  current beat
- out_last  output  1  high on the final beat of a word
- busy  output  1  a word is held, or the FIFO is non-empty
- words_done  output  CNT_WIDTH  count of fully transmitted words; wraps

Behaviour:
- State: hold register hold[WIDTH-1:0], beat index beat[BLG2-1:0], state bit st with IDLE=0 and SEND=1.
- Reset values (asynchronous on rst=0): st=IDLE, beat=0, hold=0, words_done=0, out_valid=0, out_last=0, fifo_rd=0. fifo_rd is gated low while rst=0.
- Beat handshake: a beat transfers on a cycle with out_valid & out_ready.
  - last_xfer = transfer & (beat==RATIO-1).
- Pop rule (combinational): fifo_rd = rst & ~fifo_empty & (st==IDLE | last_xfer).
  - Never asserted when fifo_empty=1, so the FIFO cannot underflow from this block.
- Capture: on a cycle with fifo_rd=1, hold <= fifo_rd_data at posedge, same cycle as the pop (FIFO read data is combinational), and beat <= 0.
- Transitions:
  - IDLE -> SEND on fifo_rd.
  - SEND stays SEND on a non-last transfer: beat <= beat+1.
  - SEND -> SEND on last_xfer with fifo_rd=1: back-to-back, no bubble.
  - SEND -> IDLE on last_xfer with fifo_rd=0.
  - SEND with no transfer: hold all state.
- Outputs:
  - out_valid = (st==SEND), registered-state driven.
  - out_data = hold[beat*OUT_WIDTH +: OUT_WIDTH] (LSB-first default).
  - out_last = (st==SEND) & (beat==RATIO-1).
  - busy = (st==SEND) | ~fifo_empty.
- Latency: FIFO non-empty in cycle N (block IDLE) -> pop in N -> first beat valid in N+1. Word throughput is RATIO cycles per word with out_ready held 1.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_last and beat must stay stable. No pop occurs in this condition.
- words_done increments by 1 on every last_xfer and wraps from 2^CNT_WIDTH-1 to 0.
- Reset mid-word: the held word and remaining beats are discarded. No further pop until rst deasserts.
  - The FIFO's own synchronous reset is managed separately by the integrator.
- X on fifo_rd_data while fifo_empty=1 must not propagate: hold is loaded only on fifo_rd.

Optional Feature:
- Macro: UNPACK_MSB_FIRST_EN.
- Defined: beats are emitted MSB-first, out_data = hold[(RATIO-1-beat)*OUT_WIDTH +: OUT_WIDTH]. All handshake and timing rules are unchanged.
- Undefined: LSB-first, as specified above.

Test Plan (WIDTH=32, OUT_WIDTH=8, RATIO=4):
- Reset values: hold rst=0 with fifo_empty=0 -> fifo_rd=0, out_valid=0, words_done=0. Release rst -> fifo_rd=1 in the first cycle, out_valid=1 in the next.
- Single word: FIFO holds 0xAABBCCDD, out_ready=1 -> beats DD,CC,BB,AA on 4 consecutive cycles, out_last only on AA, then out_valid=0 and words_done=1.
- Back-to-back: FIFO holds 0x03020100 then 0x07060504, out_ready=1 -> 8 consecutive beats 00..07 with no gap, fifo_rd pulses on cycle 0 and on the AA-equivalent cycle (beat 03), words_done=2.
- Backpressure: out_ready=0 for 3 cycles at beat 1 of 0xAABBCCDD -> out_data stays CC, fifo_rd=0 throughout, and the sequence resumes CC,BB,AA.
- Reset mid-word: assert rst at beat 2 -> out_valid drops immediately (async), beat=0, and the remaining beats are never emitted.
- UNPACK_MSB_FIRST_EN defined: word 0xAABBCCDD -> beats AA,BB,CC,DD, out_last on DD.

Source files
------------

// File: rtl/fifo_unpacker.sv
// Drains WIDTH-bit words from a synchronous FIFO and serialises each into RATIO
// OUT_WIDTH-bit beats on a valid/ready stream. Define UNPACK_MSB_FIRST_EN for MSB-first beat order.
module fifo_unpacker #(
    parameter int WIDTH     = 256,
    parameter int OUT_WIDTH = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    input  logic [WIDTH-1:0]     fifo_rd_data,
    output logic                 fifo_rd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] words_done
);
    localparam int RATIO = WIDTH / OUT_WIDTH;
    localparam int BLG2  = $clog2(RATIO);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t               st_q, st_d;
    logic [BLG2-1:0]      beat_q, beat_d;
    logic [WIDTH-1:0]     hold_q, hold_d;
    logic [CNT_WIDTH-1:0] words_done_q, words_done_d;

    logic                 xfer;
    logic                 last_beat;
    logic                 last_xfer;
    logic                 pop;
    logic [OUT_WIDTH-1:0] beat_slice [RATIO];

    // Pre-slice the held word so the output mux is a plain index by beat.
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
`ifdef UNPACK_MSB_FIRST_EN
        assign beat_slice[gi] = hold_q[(RATIO-1-gi)*OUT_WIDTH +: OUT_WIDTH];
`else
        assign beat_slice[gi] = hold_q[gi*OUT_WIDTH +: OUT_WIDTH];
`endif
    end

    assign last_beat = (beat_q == BLG2'(RATIO - 1));

    always_comb begin
        xfer         = (st_q == ST_SEND) & out_ready;
        last_xfer    = xfer & last_beat;
        pop          = rst & ~fifo_empty & ((st_q == ST_IDLE) | last_xfer);
        st_d         = st_q;
        beat_d       = beat_q;
        hold_d       = hold_q;
        words_done_d = words_done_q;
        if (last_xfer) begin
            words_done_d = words_done_q + 1'b1;
        end
        // A pop reloads the hold register; on the last beat this chains words without a bubble.
        if (pop) begin
            hold_d = fifo_rd_data;
            beat_d = '0;
            st_d   = ST_SEND;
        end else if (last_xfer) begin
            beat_d = '0;
            st_d   = ST_IDLE;
        end else if (xfer) begin
            beat_d = beat_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q         <= ST_IDLE;
            beat_q       <= '0;
            hold_q       <= '0;
            words_done_q <= '0;
        end else begin
            st_q         <= st_d;
            beat_q       <= beat_d;
            hold_q       <= hold_d;
            words_done_q <= words_done_d;
        end
    end

    assign fifo_rd    = pop;
    assign out_valid  = (st_q == ST_SEND);
    assign out_data   = beat_slice[beat_q];
    assign out_last   = (st_q == ST_SEND) & last_beat;
    assign busy       = (st_q == ST_SEND) | ~fifo_empty;
    assign words_done = words_done_q;
endmodule

// File: tb/tb_fifo_unpacker.sv
// Bench for fifo_unpacker (32-bit words, 8-bit beats): FIFO and expected beat stream
// are modelled as queues; directed cases followed by randomized traffic and backpressure.
module tb_fifo_unpacker;
    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        fifo_empty;
    logic [31:0] fifo_rd_data;
    logic        fifo_rd;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;
    logic [3:0]  words_done;

    logic [31:0] fq [$];
    beat_t       bq [$];
    logic [3:0]  wd;
    int          passed;
    int          total;

    fifo_unpacker #(.WIDTH(32), .OUT_WIDTH(8), .CNT_WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd      (fifo_rd),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .words_done   (words_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic refresh();
        fifo_empty = (fq.size() == 0);
        fifo_rd_data = fifo_empty ? 32'hxxxx_xxxx : fq[0];
    endtask

    task automatic push_word(input logic [31:0] w);
        fq.push_back(w);
        refresh();
    endtask

    // Word as seen by the consumer: a run of four beats, last flag on the fourth.
    task automatic expect_word(input logic [31:0] w);
        beat_t b;
        int    idx;
        for (int i = 0; i < 4; i++) begin
`ifdef UNPACK_MSB_FIRST_EN
            idx = 3 - i;
`else
            idx = i;
`endif
            b.d = w[idx*8 +: 8];
            b.l = (i == 3);
            bq.push_back(b);
        end
    endtask

    task automatic step(input logic rdy);
        logic exp_rd;
        logic [31:0] w;
        out_ready = rdy;
        @(negedge clk);
        // New word is needed when nothing is pending or the final pending beat leaves now.
        exp_rd = rst && (fq.size() > 0) && ((bq.size() == 0) || ((bq.size() == 1) && rdy));
        chk("fifo_rd", {31'b0, fifo_rd}, {31'b0, exp_rd});
        chk("out_valid", {31'b0, out_valid}, {31'b0, bq.size() > 0});
        if (bq.size() > 0) begin
            chk("out_data", {24'b0, out_data}, {24'b0, bq[0].d});
        end
        chk("out_last", {31'b0, out_last}, {31'b0, (bq.size() > 0) ? bq[0].l : 1'b0});
        chk("words_done", {28'b0, words_done}, {28'b0, wd});
        chk("busy", {31'b0, busy}, {31'b0, (bq.size() > 0) || (fq.size() > 0)});
        @(posedge clk);
        if (rst) begin
            if ((bq.size() > 0) && rdy) begin
                if (bq[0].l) wd = wd + 4'd1;
                void'(bq.pop_front());
            end
            if (exp_rd) begin
                w = fq.pop_front();
                expect_word(w);
            end
        end
        #1;
        refresh();
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        wd        = 4'd0;
        rst       = 1'b0;
        out_ready = 1'b0;
        refresh();

        // Held in reset with data waiting: no pop, nothing valid.
        push_word(32'hAABBCCDD);
        #2;
        chk("rst_fifo_rd", {31'b0, fifo_rd}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_words_done", {28'b0, words_done}, 32'd0);
        step(1'b1);
        step(1'b1);

        // Release: pop in the first cycle, four beats, then idle with one word done.
        rst = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b1);

        // Back-to-back words stream with no gap.
        push_word(32'h03020100);
        push_word(32'h07060504);
        for (int i = 0; i < 10; i++) step(1'b1);

        // Backpressure held for three cycles on beat 1.
        push_word(32'hAABBCCDD);
        step(1'b1);
        step(1'b1);
        for (int i = 0; i < 3; i++) step(1'b0);
        for (int i = 0; i < 4; i++) step(1'b1);

        // Reset mid-word at beat 2 with another word queued behind it.
        push_word(32'h11223344);
        push_word(32'h55667788);
        step(1'b1);
        step(1'b1);
        step(1'b1);
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_out_last", {31'b0, out_last}, 32'd0);
        chk("mid_rst_fifo_rd", {31'b0, fifo_rd}, 32'd0);
        chk("mid_rst_words_done", {28'b0, words_done}, 32'd0);
        bq.delete();
        wd = 4'd0;
        step(1'b1);
        step(1'b1);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b1);

        // Random traffic and backpressure; enough words to wrap the 4-bit counter.
        for (int n = 0; n < 400; n++) begin
            if ((fq.size() < 3) && ($urandom_range(0, 2) != 0)) push_word($urandom);
            step($urandom_range(0, 3) != 0);
        end
        for (int i = 0; (i < 100) && ((fq.size() > 0) || (bq.size() > 0)); i++) step(1'b1);
        step(1'b1);
        chk("final_out_valid", {31'b0, out_valid}, 32'd0);
        chk("final_busy", {31'b0, busy}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
